// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller for the in-order pipeline: tracks in-flight instructions in a
// shadow pipeline and decides stall, bubble and flush for every inter-stage register.
module pipeline_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_W      = 5,
  parameter int FORWARD    = 1,
  parameter int BRANCH_REG = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  input  logic                  ex_busy,
  input  logic                  perf_clear,
  output logic                  pc_write,
  output logic [NUM_STAGES-2:0] reg_hold,
  output logic [NUM_STAGES-2:0] reg_flush,
  output logic                  exec_kill,
  output logic [NUM_STAGES-2:0] stage_valid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int NR = NUM_STAGES - 1;
  // Only registers that can still cause a stall need destination info.
  localparam int META_LAST = (FORWARD != 0) ? 1 : NUM_STAGES - 3;

  logic [NR-1:0]      validQ;
  logic [REG_W-1:0]   rdQ [1:META_LAST];
  logic [META_LAST:1] regWriteQ;
  logic               memReadQ;
  logic               hazard;
  logic               stallEvt;
  logic               flushEvt;

  // RAW check of the ID instruction against the writers it cannot forward from.
  always_comb begin
    hazard = 1'b0;
    for (int i = 1; i <= META_LAST; i++) begin
      if (validQ[i] && regWriteQ[i] && (rdQ[i] != '0) && ((FORWARD == 0) || memReadQ) &&
          ((id_use_rs && (id_rs == rdQ[i])) || (id_use_rt && (id_rt == rdQ[i]))))
        hazard = 1'b1;
    end
    hazard = hazard && validQ[0];
  end

  always_comb begin
    pc_write  = 1'b1;
    reg_hold  = '0;
    reg_flush = '0;
    exec_kill = 1'b0;
    stallEvt  = 1'b0;
    flushEvt  = 1'b0;
    if (rst) begin
      pc_write  = 1'b0;
      reg_flush = '1;
    end else if (branch_taken) begin
      for (int i = 0; i <= BRANCH_REG; i++) reg_flush[i] = 1'b1;
      exec_kill = (BRANCH_REG >= 2) && ex_busy;
      flushEvt  = 1'b1;
    end else if (ex_busy) begin
      pc_write     = 1'b0;
      reg_hold[0]  = 1'b1;
      reg_hold[1]  = 1'b1;
      reg_flush[2] = 1'b1;
      stallEvt     = 1'b1;
    end else if (hazard) begin
      pc_write     = 1'b0;
      reg_hold[0]  = 1'b1;
      reg_flush[1] = 1'b1;
      stallEvt     = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      validQ    <= '0;
      regWriteQ <= '0;
      memReadQ  <= 1'b0;
      for (int i = 1; i <= META_LAST; i++) rdQ[i] <= '0;
    end else begin
      if (reg_flush[0])      validQ[0] <= 1'b0;
      else if (!reg_hold[0]) validQ[0] <= fetch_valid;
      for (int i = 1; i < NR; i++) begin
        if (reg_flush[i])      validQ[i] <= 1'b0;
        else if (!reg_hold[i]) validQ[i] <= validQ[i-1];
      end
      if (!reg_flush[1] && !reg_hold[1]) begin
        rdQ[1]       <= id_rd;
        regWriteQ[1] <= id_reg_write;
        memReadQ     <= id_mem_read;
      end
      for (int i = 2; i <= META_LAST; i++) begin
        if (!reg_flush[i] && !reg_hold[i]) begin
          rdQ[i]       <= rdQ[i-1];
          regWriteQ[i] <= regWriteQ[i-1];
        end
      end
    end
  end

  // Saturating perf counters; a clear in the same cycle beats the increment.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallEvt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEvt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stage_valid = validQ;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for no-forwarding and
// counter saturation, then random traffic against a pipeline-level reference model.
module tb_pipeline_ctrl;

  typedef struct {
    logic       fv;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rd;
    logic       rw, mr, br, busy, clr;
  } Stim;

  typedef struct {
    Stim        s;
    logic       pc;
    logic [3:0] hold, flush;
    logic       kill;
    logic [3:0] sv;
    int         stall, flc;
  } Vec;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } Entry;

  typedef enum int {kAdvance, kHazard, kBusy, kBranch} Kind_e;

  logic clock = 1'b0;
  logic rst;
  logic fetchValid, useRs, useRt, regWrite, memRead, branchTaken, exBusy, perfClear;
  logic [4:0] rs, rt, rd;

  logic pcWrite, execKill, nfPcWrite, nfExecKill, satPcWrite, satExecKill;
  logic [3:0] regHold, regFlush, stageValid;
  logic [3:0] nfHold, nfFlush, nfValid;
  logic [3:0] satHold, satFlush, satValid;
  logic [15:0] stallCnt, flushCnt, nfStallCnt, nfFlushCnt;
  logic [3:0] satStallCnt, satFlushCnt;

  int checks = 0;
  int errors = 0;

  Entry pipe [2][4];
  int stallRaw [2];
  int flushRaw [2];

  always #5 clock = ~clock;

  pipeline_ctrl #(.FORWARD(1)) dut (
    .clock(clock), .rst(rst), .fetch_valid(fetchValid), .id_rs(rs), .id_rt(rt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_rd(rd), .id_reg_write(regWrite),
    .id_mem_read(memRead), .branch_taken(branchTaken), .ex_busy(exBusy),
    .perf_clear(perfClear), .pc_write(pcWrite), .reg_hold(regHold), .reg_flush(regFlush),
    .exec_kill(execKill), .stage_valid(stageValid), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  pipeline_ctrl #(.FORWARD(0)) dutNf (
    .clock(clock), .rst(rst), .fetch_valid(fetchValid), .id_rs(rs), .id_rt(rt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_rd(rd), .id_reg_write(regWrite),
    .id_mem_read(memRead), .branch_taken(branchTaken), .ex_busy(exBusy),
    .perf_clear(perfClear), .pc_write(nfPcWrite), .reg_hold(nfHold), .reg_flush(nfFlush),
    .exec_kill(nfExecKill), .stage_valid(nfValid), .stall_cnt(nfStallCnt), .flush_cnt(nfFlushCnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dutSat (
    .clock(clock), .rst(rst), .fetch_valid(fetchValid), .id_rs(rs), .id_rt(rt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_rd(rd), .id_reg_write(regWrite),
    .id_mem_read(memRead), .branch_taken(branchTaken), .ex_busy(exBusy),
    .perf_clear(perfClear), .pc_write(satPcWrite), .reg_hold(satHold), .reg_flush(satFlush),
    .exec_kill(satExecKill), .stage_valid(satValid), .stall_cnt(satStallCnt), .flush_cnt(satFlushCnt)
  );

  function automatic Stim mkStim(logic fv, logic [4:0] srs, logic [4:0] srt, logic surs,
                                 logic surt, logic [4:0] srd, logic rw, logic mr, logic br,
                                 logic busy, logic clr);
    Stim s;
    s.fv = fv; s.rs = srs; s.rt = srt; s.urs = surs; s.urt = surt; s.rd = srd;
    s.rw = rw; s.mr = mr; s.br = br; s.busy = busy; s.clr = clr;
    return s;
  endfunction

  function automatic Vec mkVec(Stim s, logic pc, logic [3:0] hold, logic [3:0] flush,
                               logic kill, logic [3:0] sv, int stall, int flc);
    Vec v;
    v.s = s; v.pc = pc; v.hold = hold; v.flush = flush; v.kill = kill;
    v.sv = sv; v.stall = stall; v.flc = flc;
    return v;
  endfunction

  task automatic applyStimulus(Stim s);
    fetchValid = s.fv; rs = s.rs; rt = s.rt; useRs = s.urs; useRt = s.urt; rd = s.rd;
    regWrite = s.rw; memRead = s.mr; branchTaken = s.br; exBusy = s.busy; perfClear = s.clr;
  endtask

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stepCycle();
    rst = 1'b0;
  endtask

  // Reference model: each register is a slot; a cycle's decision says which slots freeze,
  // which become bubbles, and everything else takes the slot upstream of it.
  function automatic logic [3:0] holdOf(Kind_e k);
    case (k)
      kHazard: return 4'b0001;
      kBusy:   return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] flushOf(Kind_e k);
    case (k)
      kHazard: return 4'b0010;
      kBusy:   return 4'b0100;
      kBranch: return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) pipe[m][i] = '0;
      stallRaw[m] = 0;
      flushRaw[m] = 0;
    end
  endtask

  function automatic Kind_e decide(int m, Stim s);
    bit hz = 0;
    int last = (m == 0) ? 1 : 2;
    if (pipe[m][0].v) begin
      for (int i = 1; i <= last; i++) begin
        Entry e = pipe[m][i];
        if (e.v && e.rw && e.rd != 0 && (m == 1 || e.mr) &&
            ((s.urs && s.rs == e.rd) || (s.urt && s.rt == e.rd)))
          hz = 1;
      end
    end
    if (s.br) return kBranch;
    if (s.busy) return kBusy;
    if (hz) return kHazard;
    return kAdvance;
  endfunction

  task automatic modelUpdate(int m, Kind_e k, Stim s);
    Entry nx [4];
    logic [3:0] h = holdOf(k);
    logic [3:0] f = flushOf(k);
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[m][i] = '0;
      stallRaw[m] = 0;
      flushRaw[m] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (f[i]) begin
        nx[i] = pipe[m][i];
        nx[i].v = 1'b0;
      end else if (h[i]) begin
        nx[i] = pipe[m][i];
      end else if (i == 0) begin
        nx[i] = '0;
        nx[i].v = s.fv;
      end else if (i == 1) begin
        nx[i].v = pipe[m][0].v; nx[i].rd = s.rd; nx[i].rw = s.rw; nx[i].mr = s.mr;
      end else begin
        nx[i] = pipe[m][i-1];
      end
    end
    for (int i = 0; i < 4; i++) pipe[m][i] = nx[i];
    if (s.clr) begin
      stallRaw[m] = 0;
      flushRaw[m] = 0;
    end else begin
      if (k == kHazard || k == kBusy) stallRaw[m]++;
      if (k == kBranch) flushRaw[m]++;
    end
  endtask

  task automatic compareModel(int m, Kind_e k, Stim s, int n);
    logic ePc, eKill;
    logic [3:0] eHold, eFlush, eSv;
    string tag = $sformatf("rnd%0d.m%0d", n, m);
    if (rst) begin
      ePc = 0; eHold = 4'b0000; eFlush = 4'b1111; eKill = 0;
    end else begin
      ePc = (k == kAdvance || k == kBranch);
      eHold = holdOf(k);
      eFlush = flushOf(k);
      eKill = (k == kBranch) && s.busy;
    end
    for (int i = 0; i < 4; i++) eSv[i] = pipe[m][i].v;
    checkOutput({tag, ".pc"},    int'(m == 0 ? pcWrite  : nfPcWrite),  int'(ePc));
    checkOutput({tag, ".hold"},  int'(m == 0 ? regHold  : nfHold),     int'(eHold));
    checkOutput({tag, ".flush"}, int'(m == 0 ? regFlush : nfFlush),    int'(eFlush));
    checkOutput({tag, ".kill"},  int'(m == 0 ? execKill : nfExecKill), int'(eKill));
    checkOutput({tag, ".valid"}, int'(m == 0 ? stageValid : nfValid),  int'(eSv));
    checkOutput({tag, ".stall"}, int'(m == 0 ? stallCnt : nfStallCnt), stallRaw[m]);
    checkOutput({tag, ".flcnt"}, int'(m == 0 ? flushCnt : nfFlushCnt), flushRaw[m]);
  endtask

  initial begin
    Vec vecs [$];
    Stim s;
    Kind_e kinds [2];

    rst = 1'b1;
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    #1;
    checkOutput("reset.pc", int'(pcWrite), 0);
    checkOutput("reset.hold", int'(regHold), 0);
    checkOutput("reset.flush", int'(regFlush), 15);
    checkOutput("reset.kill", int'(execKill), 0);
    checkOutput("reset.valid", int'(stageValid), 0);
    checkOutput("reset.stall", int'(stallCnt), 0);
    checkOutput("reset.flcnt", int'(flushCnt), 0);
    stepCycle();
    checkOutput("resetEdge.valid", int'(stageValid), 0);
    rst = 1'b0;

    // Directed sequence with FORWARD=1: load-use, r0/use-bit cases, branch over a pending
    // load-use, multi-cycle busy interrupted by a branch, and clear beating increment.
    vecs.push_back(mkVec(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0));
    vecs.push_back(mkVec(mkStim(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0));
    vecs.push_back(mkVec(mkStim(1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0), 0, 4'b0001, 4'b0010, 0, 4'b0011, 0, 0));
    vecs.push_back(mkVec(mkStim(1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0101, 1, 0));
    vecs.push_back(mkVec(mkStim(1, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b1011, 1, 0));
    vecs.push_back(mkVec(mkStim(1, 0, 0, 1, 1, 3, 1, 1, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0111, 1, 0));
    vecs.push_back(mkVec(mkStim(1, 3, 9, 0, 1, 4, 1, 1, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b1111, 1, 0));
    vecs.push_back(mkVec(mkStim(1, 4, 0, 1, 0, 6, 1, 0, 1, 0, 0), 1, 4'b0000, 4'b0111, 0, 4'b1111, 1, 0));
    vecs.push_back(mkVec(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b1000, 1, 1));
    vecs.push_back(mkVec(mkStim(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0001, 1, 1));
    vecs.push_back(mkVec(mkStim(1, 10, 11, 1, 1, 12, 1, 0, 0, 1, 0), 0, 4'b0011, 4'b0100, 0, 4'b0011, 1, 1));
    vecs.push_back(mkVec(mkStim(1, 10, 11, 1, 1, 12, 1, 0, 1, 1, 0), 1, 4'b0000, 4'b0111, 1, 4'b0011, 2, 1));
    vecs.push_back(mkVec(mkStim(1, 10, 11, 1, 1, 12, 1, 0, 0, 1, 0), 0, 4'b0011, 4'b0100, 0, 4'b0000, 2, 2));
    vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0000, 3, 2));
    vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0, 4'b0011, 4'b0100, 0, 4'b0000, 3, 2));
    vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0));

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r].s);
      #1;
      checkOutput($sformatf("row%0d.pc", r), int'(pcWrite), int'(vecs[r].pc));
      checkOutput($sformatf("row%0d.hold", r), int'(regHold), int'(vecs[r].hold));
      checkOutput($sformatf("row%0d.flush", r), int'(regFlush), int'(vecs[r].flush));
      checkOutput($sformatf("row%0d.kill", r), int'(execKill), int'(vecs[r].kill));
      checkOutput($sformatf("row%0d.valid", r), int'(stageValid), int'(vecs[r].sv));
      checkOutput($sformatf("row%0d.stall", r), int'(stallCnt), vecs[r].stall);
      checkOutput($sformatf("row%0d.flcnt", r), int'(flushCnt), vecs[r].flc);
      stepCycle();
    end

    // Without forwarding an ALU writer stalls its reader for two cycles.
    doReset();
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stepCycle();
    applyStimulus(mkStim(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0));
    stepCycle();
    s = mkStim(1, 0, 3, 0, 1, 9, 1, 0, 0, 0, 0);
    applyStimulus(s);
    #1;
    checkOutput("nf.cycle1.pc", int'(nfPcWrite), 0);
    checkOutput("fwd.aluUse.pc", int'(pcWrite), 1);
    stepCycle();
    #1;
    checkOutput("nf.cycle2.pc", int'(nfPcWrite), 0);
    checkOutput("nf.cycle2.flush", int'(nfFlush), 2);
    stepCycle();
    #1;
    checkOutput("nf.cycle3.pc", int'(nfPcWrite), 1);
    checkOutput("nf.stall", int'(nfStallCnt), 2);
    stepCycle();

    // Narrow counter saturation under a long busy, then reset in the middle of it.
    doReset();
    s = mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(s);
    repeat (2) stepCycle();
    s.busy = 1;
    applyStimulus(s);
    for (int c = 1; c <= 20; c++) begin
      stepCycle();
      if (c == 14) checkOutput("sat.stall14", int'(satStallCnt), 14);
      if (c == 15) checkOutput("sat.stall15", int'(satStallCnt), 15);
    end
    checkOutput("sat.stall20", int'(satStallCnt), 15);
    checkOutput("wide.stall20", int'(stallCnt), 20);
    checkOutput("sat.busyValid", int'(satValid), 3);
    rst = 1'b1;
    #1;
    checkOutput("midReset.valid", int'(satValid), 0);
    checkOutput("midReset.stall", int'(satStallCnt), 0);
    checkOutput("midReset.flush", int'(satFlush), 15);
    checkOutput("midReset.pc", int'(satPcWrite), 0);
    stepCycle();
    rst = 1'b0;
    s.busy = 0;
    applyStimulus(s);
    #1;
    checkOutput("afterReset.pc", int'(satPcWrite), 1);
    checkOutput("afterReset.flush", int'(satFlush), 0);
    stepCycle();

    // Random traffic against the reference model for both forwarding modes.
    doReset();
    modelReset();
    for (int n = 0; n < 600; n++) begin
      s = mkStim($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
      applyStimulus(s);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      if (rst) modelReset();
      for (int m = 0; m < 2; m++) begin
        kinds[m] = decide(m, s);
        compareModel(m, kinds[m], s, n);
      end
      checkOutput($sformatf("rnd%0d.satStall", n), int'(satStallCnt),
                  (stallRaw[0] > 15) ? 15 : stallRaw[0]);
      @(posedge clock);
      for (int m = 0; m < 2; m++) modelUpdate(m, kinds[m], s);
      @(negedge clock);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
